// File: rtl/ternary_simd_reducer_if.sv
// Beat and result handshake bundle for the ternary reducer.
// master drives beats and accepts results; slave is the engine.
interface ternary_simd_reducer_if #(
  parameter int LANES       = 16,
  parameter int ACCUM_WIDTH = 32,
  parameter int SUM_WIDTH   = ACCUM_WIDTH + $clog2(LANES)
);
  logic                         in_valid;
  logic                         in_ready;
  logic [2*LANES-1:0]           in_weights;
  logic [2*LANES-1:0]           in_inputs;
  logic                         out_valid;
  logic                         out_ready;
  logic [LANES*ACCUM_WIDTH-1:0] out_vector;
  logic [SUM_WIDTH-1:0]         out_sum;

  modport master (
    output in_valid, in_weights, in_inputs, out_ready,
    input  in_ready, out_valid, out_vector, out_sum
  );

  modport slave (
    input  in_valid, in_weights, in_inputs, out_ready,
    output in_ready, out_valid, out_vector, out_sum
  );
endinterface

// File: rtl/ternary_simd_reducer.sv
// Streaming per-lane ternary MAC with saturate/wrap arithmetic.
// Each job ends with a serial lane reduction into one scalar.
module ternary_simd_reducer #(
  parameter int LANES       = 16,
  parameter int ACCUM_WIDTH = 32,
  parameter int SUM_WIDTH   = ACCUM_WIDTH + $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           job_len,
  input  logic [LANES-1:0]      lane_mask,
  input  logic                  weight_brdcst,
  input  logic                  clear_acc,
  input  logic                  sat_en,
  ternary_simd_reducer_if.slave bus,
  output logic [LANES-1:0]      overflow_flags,
  output logic                  busy,
  output logic [31:0]           beat_count,
  output logic [31:0]           skip_total,
  output logic [31:0]           active_lane_beats
);
  localparam int AW = ACCUM_WIDTH;
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(LANES + 1);
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);
  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] MONE = {(AW+1){1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_REDUCE,
    S_OUTPUT
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q;
  logic [15:0]           cnt_q, cnt_d;
  logic [LANES-1:0]      mask_q;
  logic                  brd_q, sat_q;
  logic                  prime_q, prime_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [AW-1:0]  acc_q [LANES];
  logic signed [AW-1:0]  acc_d [LANES];
  logic [LANES-1:0]      ovf_q, ovf_d;
  logic [SUM_WIDTH-1:0]  sum_q, sum_d;
  logic [31:0]           beat_q, skip_q, alb_q;
  logic                  accept, take_start;
  logic [1:0]            w_l [LANES];
  logic [1:0]            x_l [LANES];
  logic [LANES-1:0]      nz, neg;
  logic [CW-1:0]         skip_n, pop_n;
  logic [AW:0]           wide [LANES];

  // Trit products: nonzero when both trits are 01/10, sign from bit 1.
  always_comb begin
    nz  = '0;
    neg = '0;
    for (int i = 0; i < LANES; i++) begin
      w_l[i] = brd_q ? bus.in_weights[1:0]
                     : bus.in_weights[2*i +: 2];
      x_l[i] = bus.in_inputs[2*i +: 2];
      nz[i]  = (w_l[i][0] ^ w_l[i][1])
             & (x_l[i][0] ^ x_l[i][1]);
      neg[i] = w_l[i][1] ^ x_l[i][1];
    end
  end

  // Enabled-lane and zero-product lane counts for profiling.
  always_comb begin
    skip_n = '0;
    pop_n  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask_q[i]) begin
        pop_n = pop_n + CW'(1);
        if (!nz[i]) skip_n = skip_n + CW'(1);
      end
    end
  end

  // Per-lane accumulate with overflow detect and clamp or wrap.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < LANES; i++) begin
      acc_d[i] = acc_q[i];
      wide[i]  = {acc_q[i][AW-1], acc_q[i]}
               + (neg[i] ? MONE : ONE);
      if (take_start && clear_acc) begin
        acc_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (accept && mask_q[i] && nz[i]) begin
        if (wide[i][AW] != wide[i][AW-1]) begin
          ovf_d[i] = 1'b1;
          if (sat_q) begin
            acc_d[i] = wide[i][AW] ? ACC_MIN : ACC_MAX;
          end else begin
            acc_d[i] = wide[i][AW-1:0];
          end
        end else begin
          acc_d[i] = wide[i][AW-1:0];
        end
      end
    end
  end

  // Job sequencing, beat counting and serial lane reduction.
  always_comb begin
    state_d    = state_q;
    take_start = 1'b0;
    accept     = 1'b0;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    prime_d    = prime_q;
    sum_d      = sum_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          take_start = 1'b1;
          cnt_d      = '0;
          if (job_len == 16'd0) begin
            state_d = S_REDUCE;
            prime_d = 1'b1;
            idx_d   = '0;
            sum_d   = '0;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == len_q) begin
            state_d = S_REDUCE;
            idx_d   = '0;
            sum_d   = '0;
          end
        end
      end
      S_REDUCE: begin
        // zero-length jobs spend one extra cycle here
        if (prime_q) begin
          prime_d = 1'b0;
        end else begin
          sum_d = sum_q + (mask_q[idx_q]
                ? SUM_WIDTH'(acc_q[idx_q])
                : {SUM_WIDTH{1'b0}});
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST) state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, configuration, datapath and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      brd_q   <= 1'b0;
      sat_q   <= 1'b0;
      prime_q <= 1'b0;
      idx_q   <= '0;
      ovf_q   <= '0;
      sum_q   <= '0;
      beat_q  <= '0;
      skip_q  <= '0;
      alb_q   <= '0;
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prime_q <= prime_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
      if (take_start) begin
        len_q  <= job_len;
        mask_q <= lane_mask;
        brd_q  <= weight_brdcst;
        sat_q  <= sat_en;
      end
      if (accept) begin
        beat_q <= beat_q + 32'd1;
        alb_q  <= alb_q + 32'(pop_n);
        skip_q <= skip_q + 32'(skip_n);
      end
    end
  end

  // Flatten the lane accumulators onto the result vector.
  always_comb begin
    bus.out_vector = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.out_vector[i*AW +: AW] = acc_q[i];
    end
  end

  assign bus.in_ready      = (state_q == S_ACCUM);
  assign bus.out_valid     = (state_q == S_OUTPUT);
  assign bus.out_sum       = sum_q;
  assign busy              = (state_q != S_IDLE);
  assign overflow_flags    = ovf_q;
  assign beat_count        = beat_q;
  assign skip_total        = skip_q;
  assign active_lane_beats = alb_q;
endmodule

// File: tb/tb_ternary_simd_reducer.sv
// Directed and randomized jobs for ternary_simd_reducer.
// A plain-integer lane model supplies every expected value.
module tb_ternary_simd_reducer;
  localparam int L  = 4;
  localparam int AW = 8;
  localparam int SW = AW + $clog2(L);
  localparam int MAXV = (1 << (AW-1)) - 1;
  localparam int MINV = -(1 << (AW-1));

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   job_len;
  logic [L-1:0]  lane_mask;
  logic          weight_brdcst;
  logic          clear_acc;
  logic          sat_en;
  logic [L-1:0]  overflow_flags;
  logic          busy;
  logic [31:0]   beat_count, skip_total, active_lane_beats;

  ternary_simd_reducer_if #(
    .LANES(L), .ACCUM_WIDTH(AW), .SUM_WIDTH(SW)
  ) bus ();

  ternary_simd_reducer #(
    .LANES(L), .ACCUM_WIDTH(AW), .SUM_WIDTH(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .job_len(job_len),
    .lane_mask(lane_mask),
    .weight_brdcst(weight_brdcst),
    .clear_acc(clear_acc),
    .sat_en(sat_en),
    .bus(bus),
    .overflow_flags(overflow_flags),
    .busy(busy),
    .beat_count(beat_count),
    .skip_total(skip_total),
    .active_lane_beats(active_lane_beats)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          m_acc [L];
  logic [L-1:0] m_ovf;
  int unsigned m_beats, m_skip, m_alb;
  logic [L-1:0] j_mask;
  bit          j_brd, j_sat;

  function automatic int tv(input logic [1:0] t);
    if (t == 2'b01) return 1;
    if (t == 2'b10) return -1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < L; i++) m_acc[i] = 0;
    m_ovf = '0;
    m_beats = 0;
    m_skip = 0;
    m_alb = 0;
  endtask

  task automatic model_beat(input logic [2*L-1:0] w,
                            input logic [2*L-1:0] x);
    m_beats++;
    m_alb += $countones(j_mask);
    for (int i = 0; i < L; i++) begin
      int wv, p, t;
      if (!j_mask[i]) continue;
      wv = j_brd ? tv(w[1:0]) : tv(w[2*i +: 2]);
      p  = wv * tv(x[2*i +: 2]);
      if (p == 0) begin
        m_skip++;
        continue;
      end
      t = m_acc[i] + p;
      if (t > MAXV || t < MINV) begin
        m_ovf[i] = 1'b1;
        if (j_sat) t = (t > MAXV) ? MAXV : MINV;
        else       t = (t > MAXV) ? t - (1 << AW) : t + (1 << AW);
      end
      m_acc[i] = t;
    end
  endtask

  task automatic check_state(input string tag);
    logic [L*AW-1:0] vec;
    vec = bus.out_vector;
    for (int i = 0; i < L; i++) begin
      logic [AW-1:0] e;
      logic [AW-1:0] o;
      e = AW'(m_acc[i]);
      o = vec[i*AW +: AW];
      chk($sformatf("%s.lane%0d", tag, i), 64'(o), 64'(e));
    end
    chk({tag, ".ovf"}, 64'(overflow_flags), 64'(m_ovf));
    chk({tag, ".beats"}, 64'(beat_count), 64'(m_beats));
    chk({tag, ".skip"}, 64'(skip_total), 64'(m_skip));
    chk({tag, ".alb"}, 64'(active_lane_beats), 64'(m_alb));
  endtask

  task automatic check_sum(input string tag);
    int s;
    logic [SW-1:0] e;
    s = 0;
    for (int i = 0; i < L; i++) if (j_mask[i]) s += m_acc[i];
    e = SW'(s);
    chk({tag, ".sum"}, 64'(bus.out_sum), 64'(e));
  endtask

  task automatic run_job(input string tag, input int len,
                         input logic [L-1:0] mask, input bit brd,
                         input bit clr, input bit sat, input bit rnd,
                         input logic [2*L-1:0] fw,
                         input logic [2*L-1:0] fx,
                         input bit gaps, input int hold);
    logic [2*L-1:0] w, x;
    bit ok;
    int n;
    start = 1'b1;
    job_len = 16'(len);
    lane_mask = mask;
    weight_brdcst = brd;
    clear_acc = clr;
    sat_en = sat;
    @(posedge clk);
    #1 start = 1'b0;
    j_mask = mask;
    j_brd = brd;
    j_sat = sat;
    if (clr) begin
      for (int i = 0; i < L; i++) m_acc[i] = 0;
      m_ovf = '0;
    end
    chk({tag, ".busy"}, 64'(busy), 64'(1));
    for (int b = 0; b < len; b++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        bus.in_weights = 8'hff;
        bus.in_inputs = 8'h55;
        @(posedge clk);
        #1;
      end
      w = rnd ? (2*L)'($urandom) : fw;
      x = rnd ? (2*L)'($urandom) : fx;
      bus.in_valid = 1'b1;
      bus.in_weights = w;
      bus.in_inputs = x;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        ok = bus.in_ready;
        @(posedge clk);
        #1;
      end
      if (!ok) chk({tag, ".accept_timeout"}, 64'(0), 64'(1));
      model_beat(w, x);
      if (b == 0) check_state({tag, ".beat0"});
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 3*L) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'((len == 0) ? L+1 : L));
    check_state(tag);
    check_sum(tag);
    for (int h = 0; h < hold; h++) begin
      start = (h == 3);
      job_len = 16'd1;
      lane_mask = '1;
      clear_acc = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, ".hold_valid"}, 64'(bus.out_valid), 64'(1));
      check_sum({tag, ".hold"});
    end
    if (hold > 0) check_state({tag, ".held"});
    start = (hold > 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, ".done_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, ".done_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    job_len = '0;
    lane_mask = '0;
    weight_brdcst = 1'b0;
    clear_acc = 1'b0;
    sat_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_weights = '0;
    bus.in_inputs = '0;
    bus.out_ready = 1'b0;
    model_reset();
    j_mask = '0;
    #1;
    check_state("reset");
    chk("reset.sum", 64'(bus.out_sum), 64'(0));
    chk("reset.valid", 64'(bus.out_valid), 64'(0));
    chk("reset.ready", 64'(bus.in_ready), 64'(0));
    chk("reset.busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_job("t1", 3, 4'b1111, 0, 1, 0, 0,
            8'b01_01_01_01, 8'b11_00_10_01, 0, 0);
    chk("t1.lane0", 64'(bus.out_vector[7:0]), 64'(8'd3));
    chk("t1.lane1", 64'(bus.out_vector[15:8]), 64'(8'hfd));
    chk("t1.sum", 64'(bus.out_sum), 64'(0));
    chk("t1.skip", 64'(skip_total), 64'(6));
    chk("t1.beats", 64'(beat_count), 64'(3));
    chk("t1.alb", 64'(active_lane_beats), 64'(12));

    bus.in_valid = 1'b1;
    bus.in_weights = 8'h55;
    bus.in_inputs = 8'h55;
    repeat (3) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("idle_valid.beats", 64'(beat_count), 64'(m_beats));

    run_job("brd", 2, 4'b0101, 1, 0, 0, 0,
            8'b01_01_01_10, 8'b01_01_01_01, 0, 0);

    run_job("sat", 130, 4'b1111, 0, 1, 1, 0,
            8'h55, 8'h55, 0, 0);
    chk("sat.lane0", 64'(bus.out_vector[7:0]), 64'(8'd127));
    chk("sat.flags", 64'(overflow_flags), 64'(4'hf));
    run_job("wrap", 130, 4'b1111, 0, 1, 0, 0,
            8'h55, 8'h55, 0, 0);
    chk("wrap.lane0", 64'(bus.out_vector[7:0]), 64'(8'h82));
    chk("wrap.flags", 64'(overflow_flags), 64'(4'hf));

    run_job("multi1", 2, 4'b1011, 0, 1, 0, 0,
            8'h55, 8'h55, 0, 0);
    run_job("multi2", 2, 4'b1011, 0, 0, 0, 0,
            8'h55, 8'h55, 0, 0);
    chk("multi2.lane0", 64'(bus.out_vector[7:0]), 64'(8'd4));
    run_job("multi3", 1, 4'b1011, 0, 1, 0, 0,
            8'h55, 8'h55, 0, 0);
    chk("multi3.lane0", 64'(bus.out_vector[7:0]), 64'(8'd1));

    for (int k = 0; k < 5; k++) begin
      run_job($sformatf("rnd%0d", k), $urandom_range(1, 6),
              4'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1, '0, '0, 1, (k == 0) ? 10 : 0);
    end

    run_job("len0", 0, 4'b1111, 0, 0, 0, 0, '0, '0, 0, 0);

    start = 1'b1;
    job_len = 16'd5;
    lane_mask = '1;
    clear_acc = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_weights = 8'h55;
    bus.in_inputs = 8'h55;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_state("rst_mid");
    chk("rst_mid.sum", 64'(bus.out_sum), 64'(0));
    chk("rst_mid.valid", 64'(bus.out_valid), 64'(0));
    chk("rst_mid.busy", 64'(busy), 64'(0));
    chk("rst_mid.ready", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_after.valid", 64'(bus.out_valid), 64'(0));

    run_job("post_rst", 3, 4'b1111, 0, 0, 0, 1, '0, '0, 0, 0);
    run_job("len0b", 0, 4'b0111, 0, 0, 0, 0, '0, '0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ternary_simd_reducer.md
# ternary_simd_reducer

Streaming successor to the fixed-width SIMD ternary engine. It accepts ternary weight/input beats over a valid/ready handshake and runs a per-lane ternary MAC with selectable saturate/wrap arithmetic. At the end of each job it reduces all lanes into one scalar and presents the lane vector plus the scalar over a valid/ready output port. It sits between the PT-5 bus unpacker and the result writeback path.

## Interface
- LANES, 16: SIMD width; power of two, 2..64
- ACCUM_WIDTH, 32: signed per-lane accumulator width, 8..48
- SUM_WIDTH, ACCUM_WIDTH+$clog2(LANES): width of the reduced sum
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  job start pulse; honoured only in IDLE
- job_len  in  16  number of beats in the job; sampled on start
- lane_mask  in  LANES  lane enable vector; sampled on start
- weight_brdcst  in  1  use lane 0's weight for every lane; sampled on start
- clear_acc  in  1  zero all accumulators and overflow flags at start; sampled on start
- sat_en  in  1  1 = saturate, 0 = two's-complement wrap; sampled on start
- in_valid  in  1  beat valid
- in_ready  out  1  beat ready
- in_weights  in  2*LANES  2-bit trit per lane
- in_inputs  in  2*LANES  2-bit trit per lane
- out_valid  out  1  result valid
- out_ready  in  1  result accepted
- out_vector  out  LANES*ACCUM_WIDTH  lane accumulators
- out_sum  out  SUM_WIDTH  signed sum of enabled lanes
- overflow_flags  out  LANES  sticky per-lane overflow
- busy  out  1  state is not IDLE
- beat_count, skip_total, active_lane_beats  out  32 each  profiling counters

## Operation
- Trit encoding: 00 = 0, 01 = +1, 10 = −1, 11 = 0. Product is ternary multiply, result in {−1, 0, +1}.
- FSM states: IDLE, ACCUM, REDUCE, OUTPUT.
  - IDLE, start=1: latch all config inputs. If clear_acc=1, zero the accumulators and overflow_flags. Next state is ACCUM, or REDUCE when job_len=0.
  - ACCUM: in_ready=1. Each accepted beat (in_valid & in_ready) adds the product into every enabled lane. Masked lanes hold their value. When the beat counter reaches job_len, the next state is REDUCE.
  - REDUCE: one lane per cycle, index 0..LANES−1. The lane is sign-extended to SUM_WIDTH and added if it is enabled, otherwise 0 is added. out_sum is cleared on entry. After lane LANES−1, the next state is OUTPUT.
  - OUTPUT: out_valid=1 until out_ready=1, then IDLE.
- Arithmetic: with sat_en=1, the accumulator clamps to +2^(AW−1)−1 or −2^(AW−1). With sat_en=0 it wraps. In both cases the lane's overflow flag is set when the true result leaves the signed range. Flags are sticky until reset or clear_acc.
- Without clear_acc, accumulators carry over from the previous job. This allows multi-job accumulation.
- Counters are cumulative since reset and wrap at 2^32. They update on accepted beats only:
  - beat_count increments by 1.
  - active_lane_beats increments by popcount(lane_mask).
  - skip_total increments by the number of enabled lanes whose product is 0.
- start outside IDLE is ignored. in_valid outside ACCUM is not accepted.

## Timing
- Reset values: all outputs 0, state IDLE, accumulators and sum 0.
- Reset mid-job aborts immediately. No output is produced.
- in_ready is registered from the state, so no combinational path exists from in_valid.
- Accumulator update appears one edge after beat acceptance. Back-to-back beats are sustained at 1 per cycle.
- After the last beat is accepted at edge E, out_valid rises after edge E+LANES.
- A job_len=0 start raises out_valid LANES+1 edges after the start edge.
- out_vector and out_sum are stable while out_valid=1.
- out_valid together with out_ready=1 at an edge returns to IDLE. start is accepted on the following cycle at the earliest.
- Simultaneous events:
  - start together with out_ready in OUTPUT: start is ignored.
  - in_valid held with in_ready=0: nothing is consumed.

## Test plan
- LANES=4, AW=32, mask 1111, clear_acc, job_len=3; beats of weights all +1, inputs {+1, −1, 0, 11}. Required: out_vector {3, −3, 0, 0}, out_sum 0, skip_total 6, beat_count 3, active_lane_beats 12, out_valid after edge E+4.
- weight_brdcst=1, lane0 weight −1, other lanes' weights +1, inputs all +1, len 2, mask 0101. Required: lanes 0 and 2 = −2, lanes 1 and 3 unchanged, out_sum −4.
- AW=8, sat_en=1, 130 beats of +1·+1. Required: lane = 127, overflow set. Repeat with sat_en=0: lane = −126, overflow set.
- Two jobs, the second with clear_acc=0, len 2 each of +1. Required: out_vector = 4 in each enabled lane. A third job with clear_acc=1 and len 1 gives 1.
- Backpressure: in_valid toggles every other cycle. Required: only handshaked beats count. Hold out_ready=0 for 10 cycles: out_valid and out_sum stay stable, and start is ignored.
- Assert reset in the middle of ACCUM. Required: all outputs 0, state IDLE, no out_valid. job_len=0 yields out_sum equal to the sum of the prior accumulators.
